// File: rtl/flash_user_port.sv
// flash_user_port
//   Client-side adapter for one flash_arbit user slot. Accepts a single local
//   read/write request, runs the arbiter req/ack/done handshake, streams write
//   bytes from a local buffer into the arbiter and forwards read bytes coming
//   back from the arbiter to a local sink.
//
// Ports
//   clk_sys, rst                  clock, asynchronous active-high reset
//   op_start/op_rd/op_addr/op_len local request (start pulse, direction, address, length)
//   op_busy/op_done/op_err        local status (busy level, done pulse, error with done)
//   src_rd_en/src_rd_addr         write-buffer read strobe and byte index
//   src_rd_data                   write-buffer data, valid one cycle after src_rd_en
//   rd_byte/rd_valid/rd_idx       read bytes to local sink with 0-based index
//   user_req/user_ack             arbiter request and grant pulse
//   user_done                     command complete pulse, arbiter releases the slot
//   user_en/user_wr_data          write-data strobe and byte to arbiter
//   user_cmd                      {rd, 7'd0, len, addr}
//   user_rd_data/_valid           read byte returned by arbiter
module flash_user_port #(
    parameter int unsigned U_DLY      = 1,
    parameter logic [15:0] RD_TIMEOUT = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        op_start,
    input  logic        op_rd,
    input  logic [15:0] op_addr,
    input  logic [7:0]  op_len,
    output logic        op_busy,
    output logic        op_done,
    output logic        op_err,
    output logic        src_rd_en,
    output logic [7:0]  src_rd_addr,
    input  logic [7:0]  src_rd_data,
    output logic [7:0]  rd_byte,
    output logic        rd_valid,
    output logic [7:0]  rd_idx,
    output logic        user_req,
    input  logic        user_ack,
    output logic        user_done,
    output logic        user_en,
    output logic [31:0] user_cmd,
    output logic [7:0]  user_wr_data,
    input  logic [7:0]  user_rd_data,
    input  logic        user_rd_data_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_RWAIT = 3'd4;

    // Registered assignments carry no delay in this implementation.
    logic unused_u_dly;
    assign unused_u_dly = ^U_DLY;

    logic [2:0]  state_q, state_d;
    logic [31:0] cmd_q, cmd_d;
    logic        op_busy_q, op_busy_d;
    logic        op_done_q, op_done_d;
    logic        op_err_q, op_err_d;
    logic        src_rd_en_q, src_rd_en_d;
    logic [7:0]  src_rd_addr_q, src_rd_addr_d;
    logic        src_pend_q, src_pend_d;
    logic [7:0]  rd_byte_q, rd_byte_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_idx_q, rd_idx_d;
    logic        user_req_q, user_req_d;
    logic        user_done_q, user_done_d;
    logic        user_en_q, user_en_d;
    logic [7:0]  user_wr_data_q, user_wr_data_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;

    logic        cmd_rd;
    logic [7:0]  cmd_len;

    assign cmd_rd  = cmd_q[31];
    assign cmd_len = cmd_q[23:16];

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        op_busy_d      = op_busy_q;
        op_done_d      = 1'b0;
        op_err_d       = 1'b0;
        src_rd_en_d    = src_rd_en_q;
        src_rd_addr_d  = src_rd_addr_q;
        // Buffer data for a strobe arrives one cycle later; this marks that cycle.
        src_pend_d     = src_rd_en_q;
        rd_byte_d      = rd_byte_q;
        rd_valid_d     = 1'b0;
        rd_idx_d       = rd_idx_q;
        user_req_d     = user_req_q;
        user_done_d    = 1'b0;
        user_en_d      = 1'b0;
        user_wr_data_d = user_wr_data_q;
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        to_cnt_d       = to_cnt_q;

        // Busy stays up through the op_done cycle and drops right after it.
        if (op_done_q) begin
            op_busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (op_start && !op_busy_q) begin
                    cmd_d     = {op_rd, 7'd0, op_len, op_addr};
                    op_busy_d = 1'b1;
                    wr_cnt_d  = 8'd0;
                    rd_cnt_d  = 8'd0;
                    to_cnt_d  = 16'd0;
                    if (op_len == 8'd0) begin
                        op_done_d = 1'b1;
                        op_err_d  = 1'b1;
                    end else begin
                        user_req_d = 1'b1;
                        state_d    = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (user_ack) begin
                    user_req_d = 1'b0;
                    if (cmd_rd) begin
                        // Read command needs no data phase: release the arbiter at once.
                        user_done_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        src_rd_en_d   = 1'b1;
                        src_rd_addr_d = 8'd0;
                        state_d       = S_WDATA;
                    end
                end
            end

            S_WDATA: begin
                if (src_rd_en_q) begin
                    if (src_rd_addr_q == cmd_len - 8'd1) begin
                        src_rd_en_d   = 1'b0;
                        src_rd_addr_d = 8'd0;
                    end else begin
                        src_rd_addr_d = src_rd_addr_q + 8'd1;
                    end
                end
                if (src_pend_q) begin
                    user_en_d      = 1'b1;
                    user_wr_data_d = src_rd_data;
                    wr_cnt_d       = wr_cnt_q + 8'd1;
                end
                if (user_en_q && (wr_cnt_q == cmd_len)) begin
                    user_done_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (cmd_rd) begin
                    to_cnt_d = 16'd0;
                    state_d  = S_RWAIT;
                end else begin
                    op_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_RWAIT: begin
                if (user_rd_data_valid) begin
                    rd_valid_d = 1'b1;
                    rd_byte_d  = user_rd_data;
                    rd_idx_d   = rd_cnt_q;
                    rd_cnt_d   = rd_cnt_q + 8'd1;
                    to_cnt_d   = 16'd0;
                    if (rd_cnt_q == cmd_len - 8'd1) begin
                        op_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (to_cnt_q == RD_TIMEOUT - 16'd1) begin
                    op_done_d = 1'b1;
                    op_err_d  = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cmd_q          <= 32'd0;
            op_busy_q      <= 1'b0;
            op_done_q      <= 1'b0;
            op_err_q       <= 1'b0;
            src_rd_en_q    <= 1'b0;
            src_rd_addr_q  <= 8'd0;
            src_pend_q     <= 1'b0;
            rd_byte_q      <= 8'd0;
            rd_valid_q     <= 1'b0;
            rd_idx_q       <= 8'd0;
            user_req_q     <= 1'b0;
            user_done_q    <= 1'b0;
            user_en_q      <= 1'b0;
            user_wr_data_q <= 8'd0;
            wr_cnt_q       <= 8'd0;
            rd_cnt_q       <= 8'd0;
            to_cnt_q       <= 16'd0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            op_busy_q      <= op_busy_d;
            op_done_q      <= op_done_d;
            op_err_q       <= op_err_d;
            src_rd_en_q    <= src_rd_en_d;
            src_rd_addr_q  <= src_rd_addr_d;
            src_pend_q     <= src_pend_d;
            rd_byte_q      <= rd_byte_d;
            rd_valid_q     <= rd_valid_d;
            rd_idx_q       <= rd_idx_d;
            user_req_q     <= user_req_d;
            user_done_q    <= user_done_d;
            user_en_q      <= user_en_d;
            user_wr_data_q <= user_wr_data_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign op_busy      = op_busy_q;
    assign op_done      = op_done_q;
    assign op_err       = op_err_q;
    assign src_rd_en    = src_rd_en_q;
    assign src_rd_addr  = src_rd_addr_q;
    assign rd_byte      = rd_byte_q;
    assign rd_valid     = rd_valid_q;
    assign rd_idx       = rd_idx_q;
    assign user_req     = user_req_q;
    assign user_done    = user_done_q;
    assign user_en      = user_en_q;
    assign user_cmd     = cmd_q;
    assign user_wr_data = user_wr_data_q;

endmodule
